// File: rtl/window_streamer_if.sv
// ---------------------------------------------------------------------------
// window_streamer_if
//   Groups the start/abort control, the fixed-latency memory read port and the
//   window stream of window_streamer into one bundle.
//
//   Control : en, abort (in)           ack, done, busy, LEDs (out)
//   Memory  : rd_en, rd_row, rd_col    (out)   rd_data (in, 1 cycle after rd_en)
//   Stream  : window_data, window_valid, win_row, win_col (out)
//             window_ready (in)
//
//   master = the streamer itself, slave = the memory/correlator side.
// ---------------------------------------------------------------------------
interface window_streamer_if #(
    parameter int REGION = 80,
    parameter int WIN    = 16,
    parameter int BPW    = 4,
    parameter int PIX_W  = 8
) ();
    localparam int RW = (REGION > 1) ? $clog2(REGION) : 1;
    localparam int CW = ((REGION / BPW) > 1) ? $clog2(REGION / BPW) : 1;

    logic                                en;
    logic                                abort;
    logic                                ack;
    logic                                rd_en;
    logic [RW-1:0]                       rd_row;
    logic [CW-1:0]                       rd_col;
    logic [BPW*PIX_W-1:0]                rd_data;
    logic [WIN-1:0][WIN-1:0][PIX_W-1:0]  window_data;
    logic                                window_valid;
    logic                                window_ready;
    logic [RW-1:0]                       win_row;
    logic [RW-1:0]                       win_col;
    logic                                done;
    logic                                busy;
    logic [3:0]                          LEDs;

    modport master (
        input  en, abort, rd_data, window_ready,
        output ack, rd_en, rd_row, rd_col, window_data, window_valid,
               win_row, win_col, done, busy, LEDs
    );

    modport slave (
        output en, abort, rd_data, window_ready,
        input  ack, rd_en, rd_row, rd_col, window_data, window_valid,
               win_row, win_col, done, busy, LEDs
    );
endinterface

// File: rtl/window_streamer.sv
// ---------------------------------------------------------------------------
// window_streamer
//   Loads a REGION x REGION pixel square from word-wide memory (BPW pixels per
//   word, leftmost pixel in the most-significant slot), then presents every
//   WIN x WIN sub-window in raster order at step STRIDE on a valid/ready
//   stream. abort returns to IDLE from any state without a done pulse.
//
//   Ports: clk, rst_n (synchronous, active low) and bus (window_streamer_if
//   master modport; see the interface file for the signal list).
//
//   Parameter legality: REGION % BPW == 0, WIN <= REGION,
//   (REGION - WIN) % STRIDE == 0. The interface must be built with the same
//   REGION/WIN/BPW/PIX_W values.
// ---------------------------------------------------------------------------
module window_streamer #(
    parameter int REGION = 80,
    parameter int WIN    = 16,
    parameter int STRIDE = 1,
    parameter int BPW    = 4,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    window_streamer_if.master bus
);
    localparam int COLS = REGION / BPW;
    localparam int RW   = (REGION > 1) ? $clog2(REGION) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(REGION - 1);
    localparam logic [RW-1:0] WIN_LAST = RW'(REGION - WIN);
    localparam logic [RW-1:0] STEP     = RW'(STRIDE);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    // State codes double as the LED status pattern.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_STREAM = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rd_row_q, rd_row_d;
    logic [CW-1:0]   rd_col_q, rd_col_d;
    logic [RW-1:0]   win_row_q, win_row_d;
    logic [RW-1:0]   win_col_q, win_col_d;
    logic            done_q, done_d;
    logic            ack;

    // Address of the read issued last cycle; its data arrives this cycle.
    logic            wr_en_q;
    logic [RW-1:0]   wr_row_q;
    logic [CW-1:0]   wr_col_q;
    logic [RW-1:0]   wr_base;

    logic [PIX_W-1:0] region_q [REGION][REGION];

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        done_d    = 1'b0;
        ack       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The done cycle itself is IDLE but does not accept a start.
                if (bus.en && !bus.abort && !done_q) begin
                    ack      = 1'b1;
                    state_d  = ST_FILL;
                    rd_row_d = '0;
                    rd_col_d = '0;
                end
            end
            ST_FILL: begin
                if (rd_col_q == COL_LAST) begin
                    rd_col_d = '0;
                    if (rd_row_q == ROW_LAST) begin
                        rd_row_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        rd_row_d = rd_row_q + RW'(1);
                    end
                end else begin
                    rd_col_d = rd_col_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                // The final word lands this cycle; streaming starts next.
                state_d   = ST_STREAM;
                win_row_d = '0;
                win_col_d = '0;
            end
            ST_STREAM: begin
                if (bus.window_ready) begin
                    if (win_col_q < WIN_LAST) begin
                        win_col_d = win_col_q + STEP;
                    end else begin
                        win_col_d = '0;
                        if (win_row_q < WIN_LAST) begin
                            win_row_d = win_row_q + STEP;
                        end else begin
                            win_row_d = '0;
                            state_d   = ST_IDLE;
                            done_d    = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.abort) begin
            state_d   = ST_IDLE;
            done_d    = 1'b0;
            rd_row_d  = '0;
            rd_col_d  = '0;
            win_row_d = '0;
            win_col_d = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            done_q    <= done_d;
            wr_en_q   <= (state_q == ST_FILL);
            wr_row_q  <= rd_row_q;
            wr_col_q  <= rd_col_q;
        end
    end

    // ---------------------------------------------------------------------
    // Region storage: unpack the returned word, leftmost pixel in the MSBs
    // ---------------------------------------------------------------------
    always_comb begin
        wr_base = RW'(wr_col_q) * RW'(BPW);
    end

    // NOTE: the region array is deliberately not reset; it is fully rewritten
    // before any window is presented.
    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            for (int k = 0; k < BPW; k++) begin
                region_q[wr_row_q][wr_base + RW'(k)] <=
                    bus.rd_data[(BPW-1-k)*PIX_W +: PIX_W];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        bus.window_data = '0;
        if (state_q == ST_STREAM) begin
            for (int i = 0; i < WIN; i++) begin
                for (int j = 0; j < WIN; j++) begin
                    bus.window_data[i][j] =
                        region_q[win_row_q + RW'(i)][win_col_q + RW'(j)];
                end
            end
        end
    end

    assign bus.ack          = ack;
    assign bus.rd_en        = (state_q == ST_FILL);
    assign bus.rd_row       = rd_row_q;
    assign bus.rd_col       = rd_col_q;
    assign bus.window_valid = (state_q == ST_STREAM);
    assign bus.win_row      = win_row_q;
    assign bus.win_col      = win_col_q;
    assign bus.done         = done_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.LEDs         = {1'b0, state_q};

endmodule

// File: tb/tb_window_streamer.sv
// ---------------------------------------------------------------------------
// tb_window_streamer
//   Two instances: a small one (REGION=8, WIN=4, STRIDE=2, pixel = 8r+c) for
//   the directed corner cases, and one at default parameters
//   (pixel = (13r+c) mod 256) for the full-size run.
// ---------------------------------------------------------------------------
module tb_window_streamer;
    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    window_streamer_if #(.REGION(8), .WIN(4), .BPW(4), .PIX_W(8)) sif ();
    window_streamer_if #(.REGION(80), .WIN(16), .BPW(4), .PIX_W(8)) dif ();

    window_streamer #(.REGION(8), .WIN(4), .STRIDE(2), .BPW(4), .PIX_W(8)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.master)
    );

    window_streamer #(.REGION(80), .WIN(16), .STRIDE(1), .BPW(4), .PIX_W(8)) dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected window positions and corner pixels for the small run.
    typedef struct {
        int row;
        int col;
        int p00;
        int p33;
    } win_vec_t;

    win_vec_t tbl [9];

    function automatic logic [7:0] small_pix(input int r, input int c);
        return 8'(8 * r + c);
    endfunction

    function automatic logic [7:0] dflt_pix(input int r, input int c);
        return 8'(13 * r + c);
    endfunction

    function automatic logic [31:0] small_word(input int r, input int c);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[(3-k)*8 +: 8] = small_pix(r, 4 * c + k);
        return w;
    endfunction

    function automatic logic [31:0] dflt_word(input int r, input int c);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[(3-k)*8 +: 8] = dflt_pix(r, 4 * c + k);
        return w;
    endfunction

    // Memory models: data one cycle after the request.
    always @(posedge clk) begin
        if (sif.rd_en) sif.rd_data <= small_word(int'(sif.rd_row), int'(sif.rd_col));
        if (dif.rd_en) dif.rd_data <= dflt_word(int'(dif.rd_row), int'(dif.rd_col));
    end

    function automatic bit small_win_ok(input int r, input int c);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (sif.window_data[i][j] !== small_pix(r + i, c + j)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit dflt_win_ok(input int r, input int c);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                if (dif.window_data[i][j] !== dflt_pix(r + i, c + j)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One start on the small instance. bp: random ready. en_from > 0 holds en
    // high from that cycle on. abort_at >= 0 pulses abort in that cycle.
    task automatic run_small(input bit bp, input int en_from, input int abort_at);
        int nrd = 0;
        int widx = 0;
        int ndone = 0;
        int first_valid = -1;
        int done_cyc = -1;
        int last_hs = -1;
        bit prev_stall = 1'b0;
        logic [127:0] held = '0;
        int held_r = 0;
        int held_c = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(posedge clk); #1;
            sif.en           = (cyc == 0) || (en_from > 0 && cyc >= en_from);
            sif.abort        = (abort_at >= 0 && cyc == abort_at);
            sif.window_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (sif.en)
                check("ack", sif.ack, (cyc == 0) || (done_cyc >= 0 && cyc == done_cyc + 1));
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                check("abort_rd_en", sif.rd_en, 0);
                check("abort_valid", sif.window_valid, 0);
                check("abort_busy", sif.busy, 0);
            end
            if (sif.rd_en) begin
                check("rd_row", sif.rd_row, nrd / 2);
                check("rd_col", sif.rd_col, nrd % 2);
                nrd++;
            end
            if (sif.window_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (prev_stall) begin
                    check("hold_data", sif.window_data == held, 1);
                    check("hold_row", sif.win_row, held_r);
                    check("hold_col", sif.win_col, held_c);
                end
                if (widx < 9) begin
                    check("win_row", sif.win_row, tbl[widx].row);
                    check("win_col", sif.win_col, tbl[widx].col);
                    check("pix00", sif.window_data[0][0], tbl[widx].p00);
                    check("pix33", sif.window_data[3][3], tbl[widx].p33);
                end else begin
                    check("extra_window", widx, 8);
                end
                check("win_full", small_win_ok(int'(sif.win_row), int'(sif.win_col)), 1);
                if (sif.window_ready) begin
                    widx++;
                    last_hs    = cyc;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    held       = sif.window_data;
                    held_r     = int'(sif.win_row);
                    held_c     = int'(sif.win_col);
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (sif.done) begin
                ndone++;
                done_cyc = cyc;
                check("done_after_last", cyc, last_hs + 1);
                check("done_valid", sif.window_valid, 0);
            end
            if (en_from > 0 && done_cyc >= 0 && cyc == done_cyc + 1) break;
            if (en_from == 0 && done_cyc >= 0 && cyc == done_cyc + 2) break;
            if (abort_at >= 0 && cyc == abort_at + 3) break;
        end
        if (abort_at < 0) begin
            check("rd_count", nrd, 16);
            check("first_valid", first_valid, 18);
            check("win_count", widx, 9);
            check("done_count", ndone, 1);
        end else begin
            check("abort_no_done", ndone, 0);
            check("abort_win_count", widx, (abort_at >= 18) ? abort_at - 17 : 0);
        end
    endtask

    task automatic reset_in_stream();
        @(posedge clk); #1;
        sif.en = 1'b1;
        sif.window_ready = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            sif.en = 1'b0;
        end
        @(negedge clk);
        check("pre_rst_valid", sif.window_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", sif.window_valid, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_leds", sif.LEDs, 0);
        check("rst_done", sif.done, 0);
        check("rst_win_row", sif.win_row, 0);
        check("rst_rd_en", sif.rd_en, 0);
        sif.window_ready = 1'b1;
    endtask

    task automatic run_default();
        int nrd = 0;
        int rd_bad = 0;
        int nwin = 0;
        int win_bad = 0;
        int first_valid = -1;
        int last_hs = -1;
        int done_cyc = -1;
        int ndone = 0;
        int lr = -1;
        int lc = -1;
        int l00 = -1;
        int lff = -1;
        int f00 = -1;
        int fff = -1;
        for (int cyc = 0; cyc < 7000; cyc++) begin
            @(posedge clk); #1;
            dif.en           = (cyc == 0);
            dif.window_ready = 1'b1;
            @(negedge clk);
            if (cyc == 0) check("dflt_ack", dif.ack, 1);
            if (dif.rd_en) begin
                if (int'(dif.rd_row) != nrd / 20 || int'(dif.rd_col) != nrd % 20) rd_bad++;
                nrd++;
            end
            if (dif.window_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    f00 = int'(dif.window_data[0][0]);
                    fff = int'(dif.window_data[15][15]);
                end
                if (int'(dif.win_row) != nwin / 65 || int'(dif.win_col) != nwin % 65 ||
                    !dflt_win_ok(int'(dif.win_row), int'(dif.win_col)))
                    win_bad++;
                lr  = int'(dif.win_row);
                lc  = int'(dif.win_col);
                l00 = int'(dif.window_data[0][0]);
                lff = int'(dif.window_data[15][15]);
                nwin++;
                last_hs = cyc;
            end
            if (dif.done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
        end
        check("dflt_rd_count", nrd, 1600);
        check("dflt_rd_order_errs", rd_bad, 0);
        check("dflt_first_valid", first_valid, 1602);
        check("dflt_win_count", nwin, 4225);
        check("dflt_win_errs", win_bad, 0);
        check("dflt_first_00", f00, 0);
        check("dflt_first_ff", fff, 210);
        check("dflt_last_row", lr, 64);
        check("dflt_last_col", lc, 64);
        check("dflt_last_00", l00, 128);
        check("dflt_last_ff", lff, 82);
        check("dflt_done_count", ndone, 1);
        check("dflt_done_cycle", done_cyc, last_hs + 1);
    endtask

    initial begin
        tbl[0] = '{row: 0, col: 0, p00:  0, p33: 27};
        tbl[1] = '{row: 0, col: 2, p00:  2, p33: 29};
        tbl[2] = '{row: 0, col: 4, p00:  4, p33: 31};
        tbl[3] = '{row: 2, col: 0, p00: 16, p33: 43};
        tbl[4] = '{row: 2, col: 2, p00: 18, p33: 45};
        tbl[5] = '{row: 2, col: 4, p00: 20, p33: 47};
        tbl[6] = '{row: 4, col: 0, p00: 32, p33: 59};
        tbl[7] = '{row: 4, col: 2, p00: 34, p33: 61};
        tbl[8] = '{row: 4, col: 4, p00: 36, p33: 63};

        rst_n = 1'b0;
        sif.en = 1'b0; sif.abort = 1'b0; sif.window_ready = 1'b1;
        dif.en = 1'b0; dif.abort = 1'b0; dif.window_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_busy", sif.busy, 0);
        check("init_leds", sif.LEDs, 0);
        check("init_valid", sif.window_valid, 0);
        check("init_rd_en", sif.rd_en, 0);
        check("init_done", sif.done, 0);
        check("init_dflt_busy", dif.busy, 0);
        rst_n = 1'b1;

        run_small(1'b0, 0, -1);      // basic run, ready held high
        run_small(1'b1, 0, -1);      // back-pressure
        run_small(1'b0, 20, -1);     // en ignored while busy, held across done

        // The new run must already be filling from (0,0); cancel it in FILL.
        @(posedge clk); #1;
        sif.en = 1'b0;
        @(negedge clk);
        check("restart_rd_en", sif.rd_en, 1);
        check("restart_rd_row", sif.rd_row, 0);
        check("restart_rd_col", sif.rd_col, 0);
        check("restart_leds", sif.LEDs, 1);
        @(posedge clk); #1;
        sif.abort = 1'b1;
        @(posedge clk); #1;
        sif.abort = 1'b0;
        @(negedge clk);
        check("fill_abort_rd_en", sif.rd_en, 0);
        check("fill_abort_busy", sif.busy, 0);
        check("fill_abort_done", sif.done, 0);

        run_small(1'b0, 0, 5);       // abort during FILL
        run_small(1'b0, 0, -1);      // clean restart after abort
        run_small(1'b0, 0, 22);      // abort on the 5th window
        reset_in_stream();
        run_default();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
